// File: rtl/instr_loader.sv
// Program loader for a 16x16 instruction memory: bytes arrive high-then-low on
// push-button strobe edges while Load is held; the processor reads with 1-cycle latency.
module instr_loader (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Load,
  input  logic        Strobe,
  input  logic [7:0]  DataIn,
  input  logic [3:0]  RdAddr,
  output logic [15:0] RdData,
  output logic [4:0]  WrCount,
  output logic        Busy,
  output logic        Full,
  output logic        ExpectLo,
  output logic        Overflow,
  output logic [7:0]  Checksum
);

  typedef enum logic [1:0] {S_IDLE, S_HI, S_LO, S_FULL} state_t;

  state_t      state;
  logic        strobe_q;
  logic        strobe_edge;
  logic [3:0]  wr_ptr;
  logic [7:0]  hi_byte;
  logic [15:0] mem [16];

  assign strobe_edge = Strobe & ~strobe_q;

  // State flags decode straight from the state register, so they are glitch-free.
  assign Busy     = (state != S_IDLE);
  assign Full     = (state == S_FULL);
  assign ExpectLo = (state == S_LO);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= S_IDLE;
      strobe_q <= 1'b1;  // a button held through reset must not look like an edge
      wr_ptr   <= 4'd0;
      WrCount  <= 5'd0;
      Overflow <= 1'b0;
      Checksum <= 8'd0;
      hi_byte  <= 8'd0;
      RdData   <= 16'h0000;
      for (int i = 0; i < 16; i++) mem[i] <= 16'h0000;
    end else begin
      strobe_q <= Strobe;
      // Nonblocking read of the old word gives read-before-write on a same-address collision.
      RdData   <= mem[RdAddr];
      case (state)
        S_IDLE: begin
          if (Load) begin
            state    <= S_HI;
            wr_ptr   <= 4'd0;
            WrCount  <= 5'd0;
            Checksum <= 8'd0;
            Overflow <= 1'b0;
          end
        end
        S_HI: begin
          if (!Load) begin
            state <= S_IDLE;
          end else if (strobe_edge) begin
            hi_byte  <= DataIn;
            Checksum <= Checksum + DataIn;
            state    <= S_LO;
          end
        end
        S_LO: begin
          if (!Load) begin
            state <= S_IDLE;
          end else if (strobe_edge) begin
            mem[wr_ptr] <= {hi_byte, DataIn};
            Checksum    <= Checksum + DataIn;
            WrCount     <= WrCount + 5'd1;
            if (WrCount == 5'd15) begin
              state <= S_FULL;  // pointer stays at 15; FULL blocks any further write
            end else begin
              wr_ptr <= wr_ptr + 4'd1;
              state  <= S_HI;
            end
          end
        end
        S_FULL: begin
          if (!Load) begin
            state <= S_IDLE;
          end else if (strobe_edge) begin
            Overflow <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: a per-cycle vector table for the basic load path,
// then hand-written sequences for fill/overflow, held strobe, abort and reset corners.
module tb_instr_loader;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Load;
  logic        Strobe;
  logic [7:0]  DataIn;
  logic [3:0]  RdAddr;
  logic [15:0] RdData;
  logic [4:0]  WrCount;
  logic        Busy;
  logic        Full;
  logic        ExpectLo;
  logic        Overflow;
  logic [7:0]  Checksum;

  int total = 0;
  int bad   = 0;
  logic [3:0] rd_addr = 4'd0;

  instr_loader dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Load     (Load),
    .Strobe   (Strobe),
    .DataIn   (DataIn),
    .RdAddr   (RdAddr),
    .RdData   (RdData),
    .WrCount  (WrCount),
    .Busy     (Busy),
    .Full     (Full),
    .ExpectLo (ExpectLo),
    .Overflow (Overflow),
    .Checksum (Checksum)
  );

  // Clock and reset
  always #5 Clock = ~Clock;

  typedef struct {
    logic        load;
    logic        strobe;
    logic [7:0]  data;
    logic [3:0]  rd_addr;
    logic [4:0]  wc;
    logic        busy;
    logic        full;
    logic        exlo;
    logic        ovf;
    logic [7:0]  cks;
    logic        chk_rd;
    logic [15:0] rd;
  } vec_t;

  vec_t vecs [14];

  // Scoreboard check
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Driver tasks: apply inputs, take one clock edge, sample 1 ns later
  task automatic cycle(input logic l, input logic s, input logic [7:0] d);
    Load   = l;
    Strobe = s;
    DataIn = d;
    RdAddr = rd_addr;
    @(posedge Clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    cycle(1'b1, 1'b1, d);
    cycle(1'b1, 1'b0, d);
  endtask

  task automatic check_flags(input string tag, input logic [4:0] wc, input logic busy,
                             input logic full, input logic exlo, input logic ovf,
                             input logic [7:0] cks);
    check({tag, " WrCount"},  16'(WrCount),  16'(wc));
    check({tag, " Busy"},     16'(Busy),     16'(busy));
    check({tag, " Full"},     16'(Full),     16'(full));
    check({tag, " ExpectLo"}, 16'(ExpectLo), 16'(exlo));
    check({tag, " Overflow"}, 16'(Overflow), 16'(ovf));
    check({tag, " Checksum"}, 16'(Checksum), 16'(cks));
  endtask

  initial begin
    //             L     S     data   addr  wc    busy  full  exlo  ovf   cks    chk   rd
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 4'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'h0000};
    vecs[1]  = '{1'b1, 1'b1, 8'h12, 4'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h12, 1'b0, 16'h0000};
    vecs[2]  = '{1'b1, 1'b0, 8'h80, 4'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h12, 1'b0, 16'h0000};
    vecs[3]  = '{1'b1, 1'b1, 8'h80, 4'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h92, 1'b1, 16'h0000};
    vecs[4]  = '{1'b1, 1'b0, 8'h00, 4'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h92, 1'b1, 16'h1280};
    vecs[5]  = '{1'b1, 1'b1, 8'hFF, 4'd1, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h91, 1'b0, 16'h0000};
    vecs[6]  = '{1'b1, 1'b0, 8'h00, 4'd1, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h91, 1'b0, 16'h0000};
    vecs[7]  = '{1'b1, 1'b1, 8'h02, 4'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h93, 1'b1, 16'h0000};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 4'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h93, 1'b1, 16'hFF02};
    vecs[9]  = '{1'b1, 1'b0, 8'h00, 4'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'h1280};
    vecs[10] = '{1'b1, 1'b1, 8'hFF, 4'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 16'h0000};
    vecs[11] = '{1'b1, 1'b0, 8'h00, 4'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 16'h0000};
    vecs[12] = '{1'b1, 1'b1, 8'h02, 4'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 16'h1280};
    vecs[13] = '{1'b1, 1'b0, 8'h00, 4'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 16'hFF02};

    Reset  = 1'b1;
    Load   = 1'b0;
    Strobe = 1'b0;
    DataIn = 8'h00;
    RdAddr = 4'd0;
    @(posedge Clock);
    @(posedge Clock);
    #1;
    check_flags("reset", 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("reset RdData", RdData, 16'h0000);
    Reset = 1'b0;

    // Basic load, read-before-write and checksum wrap
    for (int i = 0; i < 14; i++) begin
      rd_addr = vecs[i].rd_addr;
      cycle(vecs[i].load, vecs[i].strobe, vecs[i].data);
      check_flags($sformatf("vec%0d", i), vecs[i].wc, vecs[i].busy, vecs[i].full,
                  vecs[i].exlo, vecs[i].ovf, vecs[i].cks);
      if (vecs[i].chk_rd) check($sformatf("vec%0d RdData", i), RdData, vecs[i].rd);
    end

    // Fill all sixteen words with (i, i), then one overflow strobe
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i));
      send_byte(8'(i));
      check($sformatf("fill%0d WrCount", i), 16'(WrCount), 16'(i + 1));
    end
    check_flags("full", 5'd16, 1'b1, 1'b1, 1'b0, 1'b0, 8'hF0);
    send_byte(8'h77);
    check_flags("overflow", 5'd16, 1'b1, 1'b1, 1'b0, 1'b1, 8'hF0);
    rd_addr = 4'd15;
    cycle(1'b1, 1'b0, 8'h00);
    check("mem15", RdData, 16'h0F0F);
    rd_addr = 4'd5;
    cycle(1'b1, 1'b0, 8'h00);
    check("mem5", RdData, 16'h0505);

    // Overflow is sticky through IDLE, cleared on the next load start
    cycle(1'b0, 1'b0, 8'h00);
    check("ovf sticky", 16'(Overflow), 16'h0001);
    cycle(1'b1, 1'b0, 8'h00);
    check("ovf cleared", 16'(Overflow), 16'h0000);

    // Strobe held high for 10 cycles gives exactly one byte
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 8'h33);
    check_flags("held", 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h33);
    cycle(1'b1, 1'b0, 8'h44);
    cycle(1'b1, 1'b1, 8'h44);
    rd_addr = 4'd0;
    cycle(1'b1, 1'b0, 8'h00);
    check("held mem0", RdData, 16'h3344);
    check("held WrCount", 16'(WrCount), 16'h0001);

    // Abort with a pending high byte, then restart
    cycle(1'b1, 1'b1, 8'hAA);
    check("abort ExpectLo", 16'(ExpectLo), 16'h0001);
    rd_addr = 4'd1;
    cycle(1'b0, 1'b0, 8'h00);
    check_flags("abort", 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h21);
    check("abort mem1", RdData, 16'h0101);
    rd_addr = 4'd0;
    cycle(1'b0, 1'b0, 8'h00);
    check("abort mem0", RdData, 16'h3344);
    cycle(1'b1, 1'b0, 8'h00);
    check_flags("restart", 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    cycle(1'b1, 1'b0, 8'h00);
    check("restart mem0", RdData, 16'h1122);
    check_flags("restart word", 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33);

    // Reset mid-load in LO with the button held through release
    cycle(1'b1, 1'b1, 8'h55);
    check("pre-reset ExpectLo", 16'(ExpectLo), 16'h0001);
    Reset = 1'b1;
    cycle(1'b1, 1'b1, 8'h55);
    check_flags("midreset", 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("midreset RdData", RdData, 16'h0000);
    cycle(1'b1, 1'b1, 8'h55);
    Reset = 1'b0;
    cycle(1'b1, 1'b1, 8'h55);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 8'h55);
    check_flags("post-reset held", 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h00);
    check("post-reset mem0", RdData, 16'h0000);
    rd_addr = 4'd15;
    cycle(1'b1, 1'b0, 8'h00);
    check("post-reset mem15", RdData, 16'h0000);

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
